// File: rtl/organ_pkg.sv
// Shared types for the organ voice and its note sequencer.
// The event duration field is sized for the widest sequencer build; narrower builds zero-extend.
package organ_pkg;

    localparam int NOTE_W    = 7;
    localparam logic [NOTE_W-1:0] REST_NOTE = '0;
    localparam int DUR_MAX_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        GAP  = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [NOTE_W-1:0]    note;
        logic [DUR_MAX_W-1:0] dur;
        logic                 last;
    } note_ev_t;

endpackage

// File: rtl/note_sequencer_if.sv
// Event handshake between the score decoder (master) and the note sequencer (slave).
interface note_sequencer_if #(
    parameter int DUR_W = 8
);
    import organ_pkg::*;

    logic              ev_valid;
    logic              ev_ready;
    logic [NOTE_W-1:0] ev_note;
    logic [DUR_W-1:0]  ev_dur;
    logic              ev_last;

    modport master (output ev_valid, ev_note, ev_dur, ev_last, input ev_ready);
    modport slave  (input ev_valid, ev_note, ev_dur, ev_last, output ev_ready);

endinterface

// File: rtl/note_fifo.sv
// First-word-fall-through event queue; the extra pointer bit separates full from empty.
module note_fifo
    import organ_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  logic     pop,
    input  logic     flush,
    input  note_ev_t wdata,
    output note_ev_t rdata,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        push_ok;
    logic        pop_ok;
    note_ev_t    mem [DEPTH];

    // A full queue refuses a push even when the same cycle pops.
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/note_sequencer.sv
// Plays queued note/duration events into the organ voice, with a silent gap after every note.
//   state | meaning
//   IDLE  | stopped, outputs silent, waiting for start
//   LOAD  | pop next event (stays here while the queue is empty -> underrun)
//   PLAY  | latched note sounds for dur * TICK_DIV cycles
//   GAP   | GAP_CYC silent cycles so repeated pitches re-articulate
module note_sequencer
    import organ_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int TICK_DIV   = 1250000,
    parameter int GAP_CYC    = 64,
    parameter int DUR_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    note_sequencer_if.slave      bus,
    input  logic                 start,
    input  logic                 stop,
    output logic [NOTE_W-1:0]    note,
    output logic                 gate,
    output logic                 busy,
    output logic                 done,
    output logic                 underrun
);

    localparam int DIV_W = $clog2(TICK_DIV);
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);

    seq_state_t        state, state_d;
    note_ev_t          head;
    note_ev_t          wr_ev;
    logic              full, empty, pop, push;

    logic [NOTE_W-1:0] lat_note, lat_note_d;
    logic              lat_last, lat_last_d;
    logic [DUR_W-1:0]  dur_cnt, dur_cnt_d;
    logic [DIV_W-1:0]  div_cnt, div_cnt_d;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_d;
    logic [NOTE_W-1:0] note_d;
    logic              gate_d, done_d, underrun_d;

    assign bus.ev_ready = !full;
    assign push  = bus.ev_valid && !full;
    assign wr_ev = '{note: bus.ev_note, dur: DUR_MAX_W'(bus.ev_dur), last: bus.ev_last};
    assign busy  = (state != IDLE);

    note_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (stop),
        .wdata (wr_ev),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d    = state;
        pop        = 1'b0;
        lat_note_d = lat_note;
        lat_last_d = lat_last;
        dur_cnt_d  = dur_cnt;
        div_cnt_d  = div_cnt;
        gap_cnt_d  = gap_cnt;
        done_d     = 1'b0;
        underrun_d = underrun;

        if (stop) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_d    = LOAD;
                        underrun_d = 1'b0;
                    end
                end
                LOAD: begin
                    if (empty) begin
                        underrun_d = 1'b1;
                    end else begin
                        pop = 1'b1;
                        // Zero-length events are dropped; a zero-length last event ends the piece.
                        if (head.dur == '0) begin
                            if (head.last) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            lat_note_d = head.note;
                            lat_last_d = head.last;
                            dur_cnt_d  = head.dur[DUR_W-1:0];
                            div_cnt_d  = '0;
                            state_d    = PLAY;
                        end
                    end
                end
                PLAY: begin
                    if (div_cnt == DIV_MAX) begin
                        div_cnt_d = '0;
                        dur_cnt_d = dur_cnt - DUR_ONE;
                        if (dur_cnt == DUR_ONE) begin
                            state_d   = GAP;
                            gap_cnt_d = GAP_LOAD;
                        end
                    end else begin
                        div_cnt_d = div_cnt + DIV_ONE;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_ONE) begin
                        state_d = lat_last ? IDLE : LOAD;
                        done_d  = lat_last;
                    end else begin
                        gap_cnt_d = gap_cnt - GAP_ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Outputs are registered from the next state so the note appears on PLAY entry.
        note_d = (state_d == PLAY) ? lat_note_d : REST_NOTE;
        gate_d = (state_d == PLAY) && (lat_note_d != REST_NOTE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            lat_note <= REST_NOTE;
            lat_last <= 1'b0;
            dur_cnt  <= '0;
            div_cnt  <= '0;
            gap_cnt  <= '0;
            note     <= REST_NOTE;
            gate     <= 1'b0;
            done     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state    <= state_d;
            lat_note <= lat_note_d;
            lat_last <= lat_last_d;
            dur_cnt  <= dur_cnt_d;
            div_cnt  <= div_cnt_d;
            gap_cnt  <= gap_cnt_d;
            note     <= note_d;
            gate     <= gate_d;
            done     <= done_d;
            underrun <= underrun_d;
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed and randomized checks of note_sequencer against a timeline model of the piece.
module tb_note_sequencer;
    import organ_pkg::*;

    localparam int TICK_DIV = 4;
    localparam int GAP_CYC  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop;
    logic [6:0] note;
    logic       gate, busy, done, underrun;

    int total = 0;
    int fails = 0;

    typedef struct {
        logic [6:0] n;
        logic [7:0] d;
        logic       l;
    } ev_t;

    ev_t         piece[$];
    logic [9:0]  exp_q[$];

    note_sequencer_if #(.DUR_W(8)) bus ();

    note_sequencer #(
        .FIFO_DEPTH (4),
        .TICK_DIV   (TICK_DIV),
        .GAP_CYC    (GAP_CYC),
        .DUR_W      (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .start    (start),
        .stop     (stop),
        .note     (note),
        .gate     (gate),
        .busy     (busy),
        .done     (done),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_ev(input logic [6:0] n, input logic [7:0] d, input logic l);
        bus.ev_valid = 1'b1;
        bus.ev_note  = n;
        bus.ev_dur   = d;
        bus.ev_last  = l;
        tick();
        bus.ev_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    // Expected {note, gate, busy, done} per cycle from the cycle after start, assuming the
    // whole piece is queued before start: one LOAD cycle per popped event, dur*TICK_DIV
    // sounding cycles, GAP_CYC silent cycles, then a done cycle after the last event.
    task automatic build_expect();
        exp_q.delete();
        foreach (piece[k]) begin
            exp_q.push_back({7'd0, 1'b0, 1'b1, 1'b0});
            if (piece[k].d != 0) begin
                repeat (int'(piece[k].d) * TICK_DIV)
                    exp_q.push_back({piece[k].n, piece[k].n != 7'd0, 1'b1, 1'b0});
                repeat (GAP_CYC) exp_q.push_back({7'd0, 1'b0, 1'b1, 1'b0});
            end
            if (piece[k].l) begin
                exp_q.push_back({7'd0, 1'b0, 1'b0, 1'b1});
                break;
            end
        end
    endtask

    task automatic run_piece(input string tag);
        build_expect();
        foreach (piece[k]) push_ev(piece[k].n, piece[k].d, piece[k].l);
        tick();
        pulse_start();
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s[%0d]", tag, i), 16'({note, gate, busy, done}), 16'(exp_q[i]));
            tick();
        end
        check({tag, "_end"}, 16'({note, gate, busy, done}), 16'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        bus.ev_valid = 1'b0;
        bus.ev_note = '0;
        bus.ev_dur = '0;
        bus.ev_last = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("reset_outs", 16'({note, gate, busy, done, underrun}), 16'd0);
        check("reset_ready", 16'(bus.ev_ready), 16'd1);

        // Two-note piece
        piece = '{'{7'd60, 8'd2, 1'b0}, '{7'd64, 8'd1, 1'b1}};
        run_piece("two_notes");

        // Single rest
        piece = '{'{7'd0, 8'd1, 1'b1}};
        run_piece("rest");

        // Zero-length event is discarded
        piece = '{'{7'd55, 8'd0, 1'b0}, '{7'd57, 8'd1, 1'b1}};
        run_piece("skip_zero");

        // Randomized pieces that fit in the queue
        for (int p = 0; p < 8; p++) begin
            int n;
            n = $urandom_range(1, 4);
            piece.delete();
            for (int k = 0; k < n; k++) begin
                ev_t e;
                e.n = 7'($urandom_range(0, 127));
                e.d = 8'($urandom_range(0, 3));
                e.l = (k == n - 1);
                piece.push_back(e);
            end
            run_piece($sformatf("rand%0d", p));
        end

        // Queue full back-pressure
        push_ev(7'd10, 8'd3, 1'b0);
        push_ev(7'd11, 8'd1, 1'b0);
        push_ev(7'd12, 8'd1, 1'b0);
        check("ready_after3", 16'(bus.ev_ready), 16'd1);
        push_ev(7'd13, 8'd1, 1'b0);
        check("ready_after4", 16'(bus.ev_ready), 16'd0);
        bus.ev_valid = 1'b1;
        bus.ev_note = 7'd70;
        bus.ev_dur = 8'd1;
        bus.ev_last = 1'b1;
        tick();
        check("fifth_held", 16'(bus.ev_ready), 16'd0);
        pulse_start();
        check("ready_in_load", 16'(bus.ev_ready), 16'd0);
        tick();
        check("ready_after_pop", 16'(bus.ev_ready), 16'd1);
        tick();
        check("fifth_accepted", 16'(bus.ev_ready), 16'd0);
        bus.ev_valid = 1'b0;
        check("full_note", 16'(note), 16'd10);
        pulse_stop();
        check("full_flushed", 16'({bus.ev_ready, busy, note}), 16'({1'b1, 1'b0, 7'd0}));

        // Underrun and recovery
        push_ev(7'd60, 8'd1, 1'b0);
        pulse_start();
        tick();
        check("ur_note60", 16'({note, gate}), 16'({7'd60, 1'b1}));
        repeat (3) tick();
        check("ur_note60_end", 16'(note), 16'd60);
        tick();
        check("ur_gap", 16'({note, gate, busy}), 16'({7'd0, 1'b0, 1'b1}));
        tick();
        tick();
        check("ur_load_not_yet", 16'(underrun), 16'd0);
        tick();
        check("ur_set", 16'({underrun, busy, note}), 16'({1'b1, 1'b1, 7'd0}));
        push_ev(7'd62, 8'd1, 1'b1);
        check("ur_pushed_silent", 16'(note), 16'd0);
        tick();
        check("ur_note62", 16'({note, gate}), 16'({7'd62, 1'b1}));
        repeat (3) tick();
        check("ur_note62_end", 16'(note), 16'd62);
        repeat (3) tick();
        check("ur_done", 16'({done, busy, underrun}), 16'({1'b1, 1'b0, 1'b1}));
        tick();
        check("ur_done_once", 16'(done), 16'd0);
        pulse_start();
        check("ur_cleared", 16'({underrun, busy}), 16'({1'b0, 1'b1}));
        pulse_stop();

        // Stop mid-note
        push_ev(7'd60, 8'd200, 1'b1);
        pulse_start();
        repeat (6) tick();
        check("stop_playing", 16'({note, gate}), 16'({7'd60, 1'b1}));
        pulse_stop();
        check("stop_idle", 16'({busy, note, gate, done, bus.ev_ready}), 16'({1'b0, 7'd0, 1'b0, 1'b0, 1'b1}));
        tick();
        check("stop_no_done", 16'(done), 16'd0);
        start = 1'b1;
        stop = 1'b1;
        bus.ev_valid = 1'b1;
        bus.ev_note = 7'd40;
        bus.ev_dur = 8'd1;
        bus.ev_last = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        bus.ev_valid = 1'b0;
        check("stop_beats_start", 16'(busy), 16'd0);
        pulse_start();
        tick();
        check("stop_push_dropped", 16'({underrun, note}), 16'({1'b1, 7'd0}));
        pulse_stop();

        // Asynchronous reset mid-note empties the queue
        push_ev(7'd57, 8'd3, 1'b0);
        push_ev(7'd59, 8'd1, 1'b1);
        pulse_start();
        repeat (4) tick();
        check("rst_before", 16'(note), 16'd57);
        #2 rst = 1'b1;
        #1;
        check("rst_async", 16'({note, gate, busy, done, underrun}), 16'd0);
        tick();
        rst = 1'b0;
        tick();
        check("rst_ready", 16'(bus.ev_ready), 16'd1);
        pulse_start();
        tick();
        check("rst_queue_empty", 16'({underrun, note}), 16'({1'b1, 7'd0}));
        pulse_stop();

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
